rvvi_tx_arbiter: RTL and testbench

RVVI_TX_ARBITER -- requirements
Module: rvvi_tx_arbiter

---
 rtl/rvvi_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_rvvi_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rvvi_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rvvi_tx_arbiter
//  Description : Arbitrates new and replay RVVI packets onto one transmitter
//                port, with burst fairness and an ack-timeout replay request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvvi_tx_arbiter #(
    parameter int WIDTH    = 792,
    parameter int MAXBURST = 4,
    parameter int TIMEOUT  = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NewValid,
    input  logic [WIDTH-1:0] NewData,
    output logic             NewStall,
    output logic             AlWen,
    output logic [WIDTH-1:0] AlWData,
    input  logic             AlFull,
    input  logic             AlEmpty,
    input  logic             ReplayValid,
    input  logic [WIDTH-1:0] ReplayData,
    output logic             ReplayStall,
    input  logic             AckValid,
    output logic             TxValid,
    output logic [WIDTH-1:0] TxData,
    input  logic             TxReady,
    output logic             TimeoutReplay
);

    localparam int c_BURST_W = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
    localparam int c_TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAXBURST);
    localparam logic [c_TMO_W-1:0]   c_TMO_TERM  = c_TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_SEND_NEW    = 2'd1;
    localparam logic [1:0] c_SEND_REPLAY = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_BURST_W-1:0] r_burst_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [WIDTH-1:0]     r_tx_data;

    logic w_new_elig;
    logic w_rep_elig;
    logic w_burst_full;
    logic w_grant_new;
    logic w_grant_rep;
    logic w_tmo_term;

    assign w_new_elig   = NewValid & ~AlFull;
    assign w_rep_elig   = ReplayValid;
    assign w_burst_full = (r_burst_cnt == c_BURST_MAX);

    // Replay has priority; a waiting new packet only wins once replay has
    // used up its burst allowance.
    assign w_grant_new = (r_state == c_IDLE) & w_new_elig & (~w_rep_elig | w_burst_full);
    assign w_grant_rep = (r_state == c_IDLE) & w_rep_elig & ~(w_new_elig & w_burst_full);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_rep) begin
                    w_next_state = c_SEND_REPLAY;
                end else if (w_grant_new) begin
                    w_next_state = c_SEND_NEW;
                end
            end
            c_SEND_NEW, c_SEND_REPLAY: begin
                if (TxReady) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (handshakes are gated by reset so they drop at once)
    // ------------------------------------------------------------------------
    always_comb begin
        NewStall    = 1'b1;
        ReplayStall = 1'b1;
        AlWen       = 1'b0;
        if (!reset) begin
            if (w_grant_new) begin
                NewStall = 1'b0;
                AlWen    = 1'b1;
            end
            if (w_grant_rep) begin
                ReplayStall = 1'b0;
            end
        end
    end

    assign TxValid = (r_state == c_SEND_NEW) | (r_state == c_SEND_REPLAY);
    assign TxData  = r_tx_data;
    assign AlWData = NewData;

    // ------------------------------------------------------------------------
    // Transmit data register and replay burst counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data   <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_grant_rep) begin
                r_tx_data <= ReplayData;
                if (!w_new_elig) begin
                    r_burst_cnt <= '0;
                end else if (!w_burst_full) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else if (w_grant_new) begin
                r_tx_data   <= NewData;
                r_burst_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ack timeout: an ack in the terminal cycle suppresses the pulse
    // ------------------------------------------------------------------------
    assign w_tmo_term    = (r_tmo_cnt == c_TMO_TERM);
    assign TimeoutReplay = ~reset & w_tmo_term & ~AckValid & ~AlEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (AckValid || AlEmpty || w_tmo_term) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvvi_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvvi_tx_arbiter
//  Description : Directed vector bench for rvvi_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvvi_tx_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         NewValid, AlFull, AlEmpty, ReplayValid, AckValid, TxReady;
    logic [W-1:0] NewData, ReplayData;
    logic         NewStall, AlWen, ReplayStall, TxValid, TimeoutReplay;
    logic [W-1:0] AlWData, TxData;

    int nvec = 0;
    int nmis = 0;

    rvvi_tx_arbiter #(.WIDTH(W), .MAXBURST(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .NewValid(NewValid), .NewData(NewData), .NewStall(NewStall),
        .AlWen(AlWen), .AlWData(AlWData), .AlFull(AlFull), .AlEmpty(AlEmpty),
        .ReplayValid(ReplayValid), .ReplayData(ReplayData), .ReplayStall(ReplayStall),
        .AckValid(AckValid), .TxValid(TxValid), .TxData(TxData), .TxReady(TxReady),
        .TimeoutReplay(TimeoutReplay)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         nv;
        logic [W-1:0] nd;
        logic         af;
        logic         ae;
        logic         rv;
        logic [W-1:0] rd;
        logic         ack;
        logic         rdy;
        logic [3:0]   eflags;   // {NewStall, ReplayStall, AlWen, TxValid}
        logic [W-1:0] etxd;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic nv, logic [W-1:0] nd, logic af, logic ae,
                                logic rv, logic [W-1:0] rd, logic ack, logic rdy,
                                logic [3:0] ef, logic [W-1:0] etxd);
        vec_t v;
        v.nv = nv; v.nd = nd; v.af = af; v.ae = ae; v.rv = rv; v.rd = rd;
        v.ack = ack; v.rdy = rdy; v.eflags = ef; v.etxd = etxd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic nv, input logic [W-1:0] nd, input logic af, input logic ae,
                         input logic rv, input logic [W-1:0] rd, input logic ack, input logic rdy);
        NewValid = nv; NewData = nd; AlFull = af; AlEmpty = ae;
        ReplayValid = rv; ReplayData = rd; AckValid = ack; TxReady = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic run_tmo(input int ackcyc, input int p1, input int p2);
        logic [63:0] g, e;
        drive(0, '0, 0, 0, 0, '0, 0, 0);
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            AckValid = (c == ackcyc);
            #4;
            g = 64'(TimeoutReplay);
            e = 64'((c == p1) || (c == p2));
            check($sformatf("tmo_ack%0d_cyc%0d", ackcyc, c), g, e);
            next_cycle();
        end
        AckValid = 1'b0;
    endtask

    initial begin
        logic [63:0] g, e;
        logic        is_new;

        vecs[0]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1100, 16'h0000);
        vecs[1]  = mk(1, 16'h00A5, 0, 1, 0, 16'h0000, 0, 1, 4'b0110, 16'h0000);
        vecs[2]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 4'b1101, 16'h00A5);
        vecs[3]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1100, 16'h00A5);
        vecs[4]  = mk(0, 16'h0000, 0, 1, 1, 16'h003C, 0, 0, 4'b1000, 16'h00A5);
        vecs[5]  = mk(1, 16'h0077, 0, 1, 1, 16'h0099, 0, 0, 4'b1101, 16'h003C);
        vecs[6]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1101, 16'h003C);
        vecs[7]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1101, 16'h003C);
        vecs[8]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1101, 16'h003C);
        vecs[9]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1101, 16'h003C);
        vecs[10] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 4'b1101, 16'h003C);
        vecs[11] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1100, 16'h003C);
        vecs[12] = mk(1, 16'h0011, 1, 1, 0, 16'h0000, 0, 0, 4'b1100, 16'h003C);
        vecs[13] = mk(1, 16'h0011, 1, 1, 1, 16'h0022, 0, 0, 4'b1000, 16'h003C);
        vecs[14] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 4'b1101, 16'h0022);
        vecs[15] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4'b1100, 16'h0022);

        reset = 1'b1;
        drive(0, '0, 0, 1, 0, '0, 0, 0);
        #1;
        g = 64'({NewStall, ReplayStall, AlWen, TxValid, TimeoutReplay, TxData});
        e = 64'({4'b1100, 1'b0, 16'h0000});
        check("reset_state", g, e);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].nv, vecs[i].nd, vecs[i].af, vecs[i].ae,
                  vecs[i].rv, vecs[i].rd, vecs[i].ack, vecs[i].rdy);
            #4;
            g = 64'({NewStall, ReplayStall, AlWen, TxValid, TimeoutReplay, TxData, AlWData});
            e = 64'({vecs[i].eflags, 1'b0, vecs[i].etxd, vecs[i].nd});
            check($sformatf("vec%0d", i), g, e);
            next_cycle();
        end

        // Active list full: new packet must never be accepted.
        for (int c = 0; c < 10; c++) begin
            drive(1, 16'h0055, 1, 1, 0, '0, 0, 1);
            #4;
            g = 64'({NewStall, AlWen, TxValid});
            e = 64'(3'b100);
            check($sformatf("alfull_cyc%0d", c), g, e);
            next_cycle();
        end

        // Both sources held: four replays then one new, repeating.
        for (int k = 0; k < 10; k++) begin
            is_new = ((k % 5) == 4);
            drive(1, 16'h0B0B, 0, 1, 1, 16'h0C0C, 0, 1);
            #4;
            g = 64'({NewStall, ReplayStall, AlWen, TxValid});
            e = is_new ? 64'(4'b0110) : 64'(4'b1000);
            check($sformatf("burst_grant%0d", k), g, e);
            next_cycle();
            #4;
            g = 64'({TxValid, TxData});
            e = 64'({1'b1, is_new ? 16'h0B0B : 16'h0C0C});
            check($sformatf("burst_xfer%0d", k), g, e);
            next_cycle();
        end

        run_tmo(0, 8, 16);
        run_tmo(5, 13, 0);
        run_tmo(8, 16, 0);

        // Reset in the middle of a stalled transfer, then immediate regrant.
        drive(0, '0, 0, 1, 1, 16'h5A5A, 0, 0);
        next_cycle();
        drive(1, 16'h1234, 0, 1, 0, '0, 0, 0);
        #4;
        check("midxfer_pre", 64'({TxValid, TxData}), 64'({1'b1, 16'h5A5A}));
        #2;
        reset = 1'b1;
        #1;
        g = 64'({NewStall, ReplayStall, AlWen, TxValid, TimeoutReplay, TxData});
        e = 64'({4'b1100, 1'b0, 16'h0000});
        check("midxfer_reset", g, e);
        next_cycle();
        reset = 1'b0;
        #4;
        check("post_reset_grant", 64'({NewStall, AlWen, TxValid}), 64'(3'b010));
        next_cycle();
        drive(0, '0, 0, 1, 0, '0, 0, 1);
        #4;
        check("post_reset_xfer", 64'({TxValid, TxData}), 64'({1'b1, 16'h1234}));
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
